avm_reg_master: RTL and testbench
=================================

// Module: avm_reg_master
// PURPOSE
//   Avalon-MM single-word master (initiator) for 32-bit control/status register slaves on the PCIe core memory bus.
//   Converts a local command handshake into one Avalon read or write.
//   Honours waitrequest and readdatavalid, then returns one response per command.
//   Strictly one transaction outstanding; no bursts, no pipelining.
// PARAMETERS
//   ADDR_W          8    Avalon word-address width
//   DATA_W          32   data width; byteenable is DATA_W/8 bits, always all-ones
//   TIMEOUT_CYCLES  255  watchdog limit in clk cycles (only with AVM_TIMEOUT_EN)
// PORTS
//   clk              in   1          clock; all logic on rising edge
//   reset_n          in   1          asynchronous, active-low reset
//   cmd_valid        in   1          command present
//   cmd_ready        out  1          block idle, command accepted this cycle if cmd_valid
//   cmd_write        in   1          1=write, 0=read
//   cmd_addr         in   ADDR_W     target word address
//   cmd_wdata        in   DATA_W     write data (ignored for reads)
//   rsp_valid        out  1          response present, held until rsp_ready
//   rsp_ready        in   1          consumer takes response
//   rsp_rdata        out  DATA_W     read data; 0 for writes and errors
//   rsp_err          out  1          1 = transaction aborted by watchdog
//   avm_address      out  ADDR_W     Avalon address
//   avm_read         out  1          Avalon read strobe
//   avm_write        out  1          Avalon write strobe
//   avm_writedata    out  DATA_W     Avalon write data
//   avm_byteenable   out  DATA_W/8   constant all-ones while a strobe is active, else 0
//   avm_waitrequest  in   1          slave stall
//   avm_readdata     in   DATA_W     slave read data
//   avm_readdatavalid in  1          slave read data valid
// BEHAVIOUR
//   - Reset: every output 0, cmd_ready 0 during reset and 1 on the first cycle after release, state IDLE.
//     Async assertion mid-transaction drops avm_read/avm_write immediately; the response is discarded.
//   - All outputs are registered.
//   - FSM: IDLE -> (WR | RD_REQ) -> [RD_WAIT] -> RESP -> IDLE.
//   - IDLE: cmd_ready=1. On cmd_valid, latch addr/wdata/write into avm_* registers.
//     Go to WR (avm_write=1) or RD_REQ (avm_read=1) on the next cycle.
//   - WR: hold avm_write, address and data while avm_waitrequest=1.
//     On the cycle waitrequest=0: drop avm_write, set rsp_valid=1, rsp_rdata=0, rsp_err=0, enter RESP.
//   - RD_REQ: hold avm_read while waitrequest=1. On the cycle waitrequest=0, drop avm_read.
//     If readdatavalid is also 1 that cycle, capture readdata and enter RESP. Otherwise enter RD_WAIT.
//   - RD_WAIT: wait for readdatavalid; capture avm_readdata into rsp_rdata and set rsp_valid; enter RESP.
//   - RESP: hold rsp_* stable until rsp_valid&&rsp_ready. Then clear rsp_valid and return to IDLE.
//     cmd_ready rises on the cycle after the handshake.
//   - Minimum latency with zero-wait slave: write cmd accepted at T0, avm_write T1, rsp_valid T2.
//     Read with readdatavalid at T1: rsp_valid T2.
//   - readdatavalid outside RD_REQ/RD_WAIT (e.g. late data after abort) is ignored.
//   - cmd_* fields are sampled only on accept; later changes have no effect.
// CONFIGURATION
//   AVM_TIMEOUT_EN defined: the watchdog counts cycles spent in WR/RD_REQ/RD_WAIT and resets to 0 on IDLE.
//     When the count reaches TIMEOUT_CYCLES, the master drops its strobe and enters RESP.
//     The response carries rsp_err=1 and rsp_rdata=0.
//   AVM_TIMEOUT_EN undefined: no counter is instantiated, rsp_err is tied to 0, and the master waits indefinitely.
// STRUCTURE
//   Package avm_master_pkg: state enum {IDLE,WR,RD_REQ,RD_WAIT,RESP}, BE_ALL_ONES constant, default widths.
//   Sub-module avm_watchdog (clear, run, expired; width clog2(TIMEOUT_CYCLES+1)), instantiated only under AVM_TIMEOUT_EN.
// TESTING
//   1. Write addr 0x00, data 0xA5A5_0F0F, waitrequest=0.
//      -> avm_write one cycle with that data, byteenable=0xF; rsp_valid next cycle, err=0.
//   2. Read addr 0x00, slave waitrequest 3 cycles, readdatavalid 2 cycles later with 0x1234_5678.
//      -> avm_read held exactly 4 cycles; rsp_rdata=0x1234_5678.
//   3. Read with readdatavalid in the same cycle waitrequest falls.
//      -> RD_WAIT skipped, rsp_valid next cycle.
//   4. rsp_ready held 0 for 5 cycles with a new cmd_valid pending.
//      -> rsp stable, cmd_ready=0 until handshake; second command starts after it.
//   5. AVM_TIMEOUT_EN, TIMEOUT_CYCLES=16, waitrequest stuck 1.
//      -> strobe drops after 16 cycles, rsp_err=1, rsp_rdata=0; late readdatavalid ignored.
//   6. reset_n pulsed low mid-RD_WAIT.
//      -> all outputs 0 asynchronously; no rsp_valid after release; next command completes normally.

Source files
------------

// File: rtl/avm_master_pkg.sv
// Shared types and defaults for the Avalon-MM single-word register master.
// The optional watchdog is enabled by defining AVM_TIMEOUT_EN.
package avm_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_e;

    localparam int unsigned DEF_ADDR_W         = 8;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    // Wide enough for data buses up to 128 bits; narrowed at the point of use.
    localparam int unsigned             MAX_BE_W    = 16;
    localparam logic [MAX_BE_W-1:0]     BE_ALL_ONES = '1;

endpackage

// File: rtl/avm_watchdog.sv
// Cycle watchdog for the Avalon master: counts while run is high, clears on clear.
// Only instantiated when AVM_TIMEOUT_EN is defined.
module avm_watchdog
    import avm_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Fires during the cycle whose edge brings the count to TIMEOUT_CYCLES,
    // so the strobe is held for exactly TIMEOUT_CYCLES cycles.
    assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/avm_reg_master.sv
// Avalon-MM single-word master: one local command becomes one Avalon read or write.
// Define AVM_TIMEOUT_EN to add a watchdog that aborts stalled transactions with rsp_err.
module avm_reg_master
    import avm_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,

    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    localparam int unsigned     BE_W  = DATA_W / 8;
    localparam logic [BE_W-1:0] BE_ON = BE_W'(BE_ALL_ONES);

    state_e              state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [ADDR_W-1:0]   avm_address_q;
    logic                avm_read_q;
    logic                avm_write_q;
    logic [DATA_W-1:0]   avm_writedata_q;
    logic [BE_W-1:0]     avm_byteenable_q;

    logic                wd_expired;

`ifdef AVM_TIMEOUT_EN
    logic wd_clear;
    logic wd_run;

    assign wd_clear = (state_q == IDLE);
    assign wd_run   = (state_q == WR) || (state_q == RD_REQ) || (state_q == RD_WAIT);

    avm_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (wd_expired)
    );
`else
    // Without the watchdog the master waits indefinitely; the limit is only a tie-off.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign wd_expired     = 1'b0;
`endif

    // NOTE: the asynchronous reset clears every output register, so strobes drop the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            cmd_ready_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_err_q        <= 1'b0;
            avm_address_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every branch read pre-edge register values.
            case (state_q)
                IDLE: begin
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q      <= 1'b0;
                        avm_address_q    <= cmd_addr;
                        avm_writedata_q  <= cmd_wdata;
                        avm_byteenable_q <= BE_ON;
                        if (cmd_write) begin
                            avm_write_q <= 1'b1;
                            state_q     <= WR;
                        end else begin
                            avm_read_q  <= 1'b1;
                            state_q     <= RD_REQ;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                WR: begin
                    if (!avm_waitrequest || wd_expired) begin
                        avm_write_q      <= 1'b0;
                        avm_byteenable_q <= '0;
                        rsp_valid_q      <= 1'b1;
                        rsp_rdata_q      <= '0;
                        rsp_err_q        <= avm_waitrequest;
                        state_q          <= RESP;
                    end
                end

                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read_q       <= 1'b0;
                        avm_byteenable_q <= '0;
                        if (avm_readdatavalid) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= avm_readdata;
                            rsp_err_q   <= 1'b0;
                            state_q     <= RESP;
                        end else begin
                            state_q     <= RD_WAIT;
                        end
                    end else if (wd_expired) begin
                        avm_read_q       <= 1'b0;
                        avm_byteenable_q <= '0;
                        rsp_valid_q      <= 1'b1;
                        rsp_rdata_q      <= '0;
                        rsp_err_q        <= 1'b1;
                        state_q          <= RESP;
                    end
                end

                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= avm_readdata;
                        rsp_err_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (wd_expired) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;

endmodule

// File: tb/tb_avm_reg_master.sv
// Directed bench for avm_reg_master with hand-computed expectations.
// Timeout expectations depend on whether AVM_TIMEOUT_EN is defined (limit set to 16 here).
module tb_avm_reg_master;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO    = 16;

    logic                clk;
    logic                reset_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;

    int n_checks = 0;
    int n_pass   = 0;

    avm_reg_master #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed still running, expected finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 8'hFF;
        cmd_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_cleared"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_cmd_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int n;

        reset_n           = 1'b0;
        cmd_valid         = 1'b0;
        cmd_write         = 1'b0;
        cmd_addr          = '0;
        cmd_wdata         = '0;
        rsp_ready         = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;

        tick();
        tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_outputs", {rsp_valid, rsp_err, avm_read, avm_write, avm_byteenable}, 32'd0);
        check("rst_data", rsp_rdata | avm_writedata | {24'd0, avm_address}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: zero-wait write
        issue(1'b1, 8'h00, 32'hA5A5_0F0F);
        check("wr_strobe", {avm_write, avm_read, avm_byteenable}, {26'd0, 1'b1, 1'b0, 4'hF});
        check("wr_data", avm_writedata, 32'hA5A5_0F0F);
        check("wr_addr", {24'd0, avm_address}, 32'h00);
        check("wr_busy", {cmd_ready, rsp_valid}, 32'd0);
        tick();
        check("wr_strobe_drop", {avm_write, avm_byteenable}, 32'd0);
        check("wr_rsp", {rsp_valid, rsp_err}, 32'b10);
        check("wr_rdata", rsp_rdata, 32'd0);
        handshake("wr");

        // 2: read with 3 wait cycles, data 2 cycles after waitrequest falls
        avm_waitrequest = 1'b1;
        issue(1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 4; i++) begin
            avm_waitrequest = (i < 3);
            check($sformatf("rd_held_%0d", i), {avm_read, avm_byteenable}, 32'h1F);
            if (i < 3) tick();
        end
        tick();
        check("rd_released", {avm_read, rsp_valid, avm_byteenable}, 32'd0);
        tick();
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h1234_5678;
        check("rd_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hDEAD_0000;
        check("rd_rsp", {rsp_valid, rsp_err}, 32'b10);
        check("rd_rdata", rsp_rdata, 32'h1234_5678);
        handshake("rd");

        // 3: readdatavalid with the falling waitrequest skips RD_WAIT
        issue(1'b0, 8'h3C, 32'h0);
        check("rd_fast_addr", {23'd0, avm_read, avm_address}, 32'h13C);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hCAFE_F00D;
        tick();
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        check("rd_fast_rsp", {avm_read, rsp_valid}, 32'b01);
        check("rd_fast_rdata", rsp_rdata, 32'hCAFE_F00D);
        handshake("rd_fast");

        // 4: response back-pressure with the next command already pending
        issue(1'b1, 8'h3C, 32'h1122_3344);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_%0d", i), {rsp_valid, rsp_err, cmd_ready, avm_read}, 32'b1000);
            check($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_after_hs", {rsp_valid, cmd_ready, avm_read}, 32'b010);
        tick();
        cmd_valid         = 1'b0;
        check("bp_second_cmd", {23'd0, avm_read, avm_address}, 32'h110);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h55AA_55AA;
        tick();
        avm_readdatavalid = 1'b0;
        check("bp_second_rdata", {rsp_valid, 31'd0} | (rsp_rdata & 32'h7FFF_FFFF), 32'hD5AA_55AA);
        handshake("bp");

        // 5: waitrequest stuck high
        avm_waitrequest = 1'b1;
        issue(1'b0, 8'h20, 32'h0);
        n = 0;
        while (avm_read && n < 40) begin
            n++;
            tick();
        end
`ifdef AVM_TIMEOUT_EN
        check("tmo_strobe_cycles", n, TMO);
        check("tmo_rsp", {rsp_valid, rsp_err, avm_read}, 32'b110);
        check("tmo_rdata", rsp_rdata, 32'd0);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_BEEF;
        tick();
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        check("tmo_late_data", rsp_rdata, 32'd0);
        handshake("tmo");
`else
        check("notmo_strobe_cycles", n, 40);
        check("notmo_still_waiting", {rsp_valid, rsp_err, avm_read}, 32'b001);
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h0BAD_CAFE;
        tick();
        avm_readdatavalid = 1'b0;
        check("notmo_rsp", {rsp_valid, rsp_err}, 32'b10);
        check("notmo_rdata", rsp_rdata, 32'h0BAD_CAFE);
        handshake("notmo");
`endif
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h7777_7777;
        tick();
        avm_readdatavalid = 1'b0;
        check("idle_rdv_ignored", {31'd0, rsp_valid}, 32'd0);

        // 6a: reset while the read strobe is stalled
        avm_waitrequest = 1'b1;
        issue(1'b0, 8'h44, 32'h0);
        check("rst_rdreq_strobe", {31'd0, avm_read}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_rdreq_async", {cmd_ready, avm_read, avm_byteenable}, 32'd0);
        check("rst_rdreq_addr", {24'd0, avm_address}, 32'd0);
        tick();
        reset_n         = 1'b1;
        avm_waitrequest = 1'b0;
        tick();
        check("rst_rdreq_release", {cmd_ready, avm_read}, 32'b10);

        // 6b: reset in RD_WAIT, late data afterwards must not produce a response
        issue(1'b0, 8'h44, 32'h0);
        tick();
        check("rst_rdwait_state", {avm_read, rsp_valid}, 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_rdwait_async", {cmd_ready, rsp_valid, avm_read, avm_write}, 32'd0);
        tick();
        reset_n           = 1'b1;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h9999_9999;
        tick();
        avm_readdatavalid = 1'b0;
        tick();
        check("rst_no_stale_rsp", {rsp_valid, cmd_ready}, 32'b01);

        issue(1'b1, 8'h07, 32'h0102_0304);
        check("post_rst_wr", {avm_write, avm_byteenable}, 32'h1F);
        check("post_rst_wdata", avm_writedata, 32'h0102_0304);
        tick();
        check("post_rst_rsp", {rsp_valid, rsp_err, avm_write}, 32'b100);
        handshake("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
